// File: rtl/rgb_fade_pkg.sv
// Shared definitions for the RGB fade/PWM stage.
// Holds the default PWM width, the matching full-scale duty, a ceil-log2 helper
// used to size the step prescaler, and the idle/lit LED levels for a given polarity.
package rgb_fade_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned MAX_DEF      = (1 << PWM_BITS_DEF) - 1;

  // Ceil(log2(v)), never below 1 so a counter of this width always exists.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Pin level for a dark LED: high when the board drives LEDs active-low.
  function automatic logic led_off(input bit active_low);
    return active_low;
  endfunction

  function automatic logic led_on(input bit active_low);
    return !active_low;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// One colour channel of the fade stage.
// Ramps a duty register toward full-on or full-off one LSB per step_tick, copies it
// into the compare register only at the end of a PWM period, and drives a registered
// PWM output from the shared counter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   step_tick    one-cycle strobe: move duty one step toward the target
//   period_end   high when pwm_cnt is at full scale (last clock of the period)
//   pwm_cnt      shared free-running PWM counter
//   level        target level (1 = fade to on, 0 = fade to off)
//   led          registered PWM pin drive
//   at_target    combinational: duty equals the current target
module fade_channel
  import rgb_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_tick,
  input  logic                period_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                level,
  output logic                led,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX     = '1;
  localparam logic                LED_OFF = led_off(ACTIVE_LOW != 0);
  localparam logic                LED_ON  = led_on(ACTIVE_LOW != 0);

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_active_q;
  logic                on;
  logic                led_q;

  assign target    = level ? MAX : '0;
  assign at_target = (duty_q == target);

  // Target is an endpoint, so moving toward it can never wrap.
  always_comb begin
    duty_d = duty_q;
    if (step_tick) begin
      if (duty_q < target) begin
        duty_d = duty_q + 1'b1;
      end else if (duty_q > target) begin
        duty_d = duty_q - 1'b1;
      end
    end
  end

  // Full scale is forced on so a fully lit LED has no one-clock dropout at pwm_cnt==MAX.
  assign on = (duty_active_q == MAX) || (pwm_cnt < duty_active_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q        <= '0;
      duty_active_q <= '0;
      led_q         <= LED_OFF;
    end else begin
      duty_q <= duty_d;
      // Loads the pre-step duty when a step lands on the period's last clock.
      if (period_end) duty_active_q <= duty_q;
      led_q <= on ? LED_ON : LED_OFF;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB fade/PWM output stage.
// Turns the blink stage's hard on/off levels into smooth fades rendered by a shared
// free-running PWM counter, and reports when every channel has reached its endpoint.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_r, in_g, in_b   target levels from the blink stage (synchronous to clk)
//   led_r/g/b          registered PWM pin drives (inverted when ACTIVE_LOW)
//   settled            registered: all duties equal their targets
module rgb_fade_pwm
  import rgb_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
  parameter int unsigned STEP_DIV   = 16384,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_r,
  input  logic in_g,
  input  logic in_b,
  output logic led_r,
  output logic led_g,
  output logic led_b,
  output logic settled
);

  localparam int unsigned PRE_W = clog2(STEP_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [PRE_W-1:0]    presc_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                step_tick;
  logic                period_end;
  logic [2:0]          at_target;
  logic                settled_q;

  assign step_tick  = (presc_q == PRE_LAST);
  assign period_end = &pwm_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      settled_q <= 1'b1;
    end else begin
      presc_q   <= step_tick ? '0 : presc_q + PRE_W'(1);
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      settled_q <= &at_target;
    end
  end

  assign settled = settled_q;

  fade_channel #(
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_ch_r (
    .clk        (clk),
    .rst        (rst),
    .step_tick  (step_tick),
    .period_end (period_end),
    .pwm_cnt    (pwm_cnt_q),
    .level      (in_r),
    .led        (led_r),
    .at_target  (at_target[2])
  );

  fade_channel #(
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_ch_g (
    .clk        (clk),
    .rst        (rst),
    .step_tick  (step_tick),
    .period_end (period_end),
    .pwm_cnt    (pwm_cnt_q),
    .level      (in_g),
    .led        (led_g),
    .at_target  (at_target[1])
  );

  fade_channel #(
    .PWM_BITS   (PWM_BITS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_ch_b (
    .clk        (clk),
    .rst        (rst),
    .step_tick  (step_tick),
    .period_end (period_end),
    .pwm_cnt    (pwm_cnt_q),
    .level      (in_b),
    .led        (led_b),
    .at_target  (at_target[0])
  );

endmodule

// File: tb/tb_rgb_fade_pwm.sv
module tb_rgb_fade_pwm;

  localparam int NB   = 4;
  localparam int PER  = 1 << NB;
  localparam int MAXV = PER - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_r = 1'b0, in_g = 1'b0, in_b = 1'b0;
  logic led_r0, led_g0, led_b0, settled0;
  logic led_r1, led_g1, led_b1, settled1;

  always #5 clk = ~clk;

  // Instance 0: active-high, 4 clocks per step. Instance 1: active-low, step every clock.
  rgb_fade_pwm #(.PWM_BITS(NB), .STEP_DIV(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .led_r(led_r0), .led_g(led_g0), .led_b(led_b0), .settled(settled0)
  );

  rgb_fade_pwm #(.PWM_BITS(NB), .STEP_DIV(1), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .settled(settled1)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: time is a clock count since reset; PWM phase and step
  // instants follow from it by modular arithmetic.
  int sdiv[2] = '{4, 1};
  int alow[2] = '{0, 1};
  longint cyc[2];
  int duty[2][3];
  int dact[2][3];

  logic [7:0] exp_q[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0;
      for (int c = 0; c < 3; c++) begin
        duty[k][c] = 0;
        dact[k][c] = 0;
      end
    end
  endtask

  // Expected {led_r, led_g, led_b, settled} after the coming clock edge, then advance.
  task automatic model_edge(input int k, input logic [2:0] lvl, output logic [3:0] e);
    int pwm;
    int tgt;
    int old_duty[3];
    logic all_eq;
    pwm = int'(cyc[k] % PER);
    all_eq = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tgt = lvl[2-c] ? MAXV : 0;
      e[3-c] = ((dact[k][c] == MAXV) || (pwm < dact[k][c])) ^ alow[k][0];
      if (duty[k][c] != tgt) all_eq = 1'b0;
      old_duty[c] = duty[k][c];
      if ((cyc[k] % sdiv[k]) == sdiv[k] - 1) begin
        if (duty[k][c] < tgt) duty[k][c]++;
        else if (duty[k][c] > tgt) duty[k][c]--;
      end
      if (pwm == MAXV) dact[k][c] = old_duty[c];
    end
    e[0] = all_eq;
    cyc[k]++;
  endtask

  task automatic push_expect(input logic [2:0] lvl);
    logic [3:0] e0, e1;
    model_edge(0, lvl, e0);
    model_edge(1, lvl, e1);
    exp_q.push_back({e0, e1});
  endtask

  task automatic step(input logic [2:0] lvl);
    @(negedge clk);
    {in_r, in_g, in_b} = lvl;
    push_expect(lvl);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({led_r0, led_g0, led_b0, settled0} !== 4'b0001) begin
      failures++;
      $display("FAIL %s dut0: got %b want 0001", name, {led_r0, led_g0, led_b0, settled0});
    end
    checks++;
    if ({led_r1, led_g1, led_b1, settled1} !== 4'b1111) begin
      failures++;
      $display("FAIL %s dut_al: got %b want 1111", name, {led_r1, led_g1, led_b1, settled1});
    end
  endtask

  // Asserts reset mid-cycle, checks the async effect, releases at a falling edge.
  task automatic do_reset(input logic [2:0] lvl);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    {in_r, in_g, in_b} = lvl;
    push_expect(lvl);
  endtask

  // Monitor: every post-reset edge produces one registered output vector.
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({led_r0, led_g0, led_b0, settled0} !== e[7:4]) begin
        failures++;
        $display("FAIL cycle_out dut0 t=%0t: got rgb_s=%b want %b", $time,
                 {led_r0, led_g0, led_b0, settled0}, e[7:4]);
      end
      checks++;
      if ({led_r1, led_g1, led_b1, settled1} !== e[3:0]) begin
        failures++;
        $display("FAIL cycle_out dut_al t=%0t: got rgb_s=%b want %b", $time,
                 {led_r1, led_g1, led_b1, settled1}, e[3:0]);
      end
    end
  end

  initial begin
    logic [2:0] lvl;
    int hold;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_state");

    // Idle with all targets low: outputs stay dark and settled.
    do_reset(3'b000);
    repeat (200) step(3'b000);

    // Red fades to full, then stays fully on.
    do_reset(3'b100);
    repeat (140) step(3'b100);

    // Green reverses at duty 6 and fades back to zero.
    do_reset(3'b010);
    n = 0;
    while (duty[0][1] != 6 && n < 200) begin
      step(3'b010);
      n++;
    end
    checks++;
    if (duty[0][1] != 6) begin
      failures++;
      $display("FAIL green_reach6: model duty %0d want 6", duty[0][1]);
    end
    repeat (80) step(3'b000);

    // Reset while all channels are partway up, then ramp again from zero.
    do_reset(3'b111);
    n = 0;
    while (duty[0][0] != 9 && n < 200) begin
      step(3'b111);
      n++;
    end
    do_reset(3'b111);
    repeat (100) step(3'b111);

    // Random level changes, including reversals mid-ramp.
    lvl = 3'($urandom);
    hold = 0;
    repeat (2000) begin
      if (hold == 0) begin
        lvl = 3'($urandom);
        hold = int'($urandom_range(1, 48));
      end
      hold--;
      step(lvl);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb_fade_pwm.md
Name: rgb_fade_pwm

Overview:
- Downstream stage of the counter-based RGB blinker: consumes its three on/off channel levels and drives the physical RGB LED pins.
- Hard on/off edges become smooth fades. A per-channel duty value ramps toward full-on or full-off at a fixed step rate and is rendered by a shared free-running PWM counter.
- Sits between the blink logic and the board LED pins, in the same clock domain as the blink logic.

Parameters:
- PWM_BITS, 8, width of the PWM counter and of each duty register; MAX = 2^PWM_BITS-1.
- STEP_DIV, 16384, clocks per duty step; must be >= 1. Full ramp 0<->MAX takes MAX*STEP_DIV clocks.
- ACTIVE_LOW, 0, when 1 all LED outputs are inverted (LED off = 1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_r  in  1  red target level from blink stage (1 = fade to on, 0 = fade to off); synchronous to clk
- in_g  in  1  green target level, same rules
- in_b  in  1  blue target level, same rules
- led_r  out  1  red PWM drive, registered
- led_g  out  1  green PWM drive, registered
- led_b  out  1  blue PWM drive, registered
- settled  out  1  high when every channel's duty equals its target, registered

Behaviour:
Reset (async assert, sync release):
- pwm_cnt=0, prescaler=0, all duty=0, all duty_active=0.
- led_* = ACTIVE_LOW (LED off), settled=1.

Prescaler:
- Counts 0..STEP_DIV-1 and wraps to 0.
- step_tick is high for exactly one cycle when prescaler==STEP_DIV-1.
- STEP_DIV=1 gives step_tick every cycle.

PWM counter:
- pwm_cnt increments every cycle and wraps MAX->0.
- One PWM period is 2^PWM_BITS clocks.

Per channel (identical for r, g, b):
- target = in_x ? MAX : 0, sampled combinationally each cycle.
- On step_tick:
  - duty<target: duty+1.
  - duty>target: duty-1.
  - equal: hold.
- Saturating: duty never wraps.
- in_x changing mid-ramp reverses direction at the next step_tick; there is no restart from the endpoint.
- Glitch-free update: duty_active <= duty only on the cycle where pwm_cnt==MAX. It holds for the rest of the period.
- Output compare: on = (duty_active==MAX) ? 1 : (pwm_cnt < duty_active).
  - duty_active=0: constantly off.
  - duty_active=MAX: constantly on (no 1-clock dropout).
- led_x <= on XOR ACTIVE_LOW. The output register adds 1 cycle latency versus pwm_cnt.

Simultaneous events:
- step_tick and pwm_cnt==MAX in the same cycle: duty_active loads the pre-step duty; the new duty appears one period later.

settled:
- settled <= AND over channels of (duty==target).
- Deasserts the cycle after any in_x changes to a value differing from its duty endpoint.

Reset mid-ramp:
- All state returns to reset values immediately.
- After release, ramping restarts from duty 0.

Width rules:
- Prescaler width = clog2(STEP_DIV), minimum 1.
- Comparisons are unsigned at PWM_BITS width.

Decomposition:
- Shared package rgb_fade_pkg:
  - PWM_BITS default and MAX constant
  - clog2 helper function
  - LED_OFF/LED_ON constants derived from ACTIVE_LOW
- Sub-module fade_channel, instantiated 3x. It holds duty, duty_active, compare and output register. Inputs: clk, rst, step_tick, period_end, pwm_cnt, target level. Outputs: led, at_target.
- Top level holds the prescaler, pwm_cnt and the settled AND.

Test Plan (PWM_BITS=4, STEP_DIV=4, ACTIVE_LOW=0 unless stated):
- Reset check: assert rst mid-cycle with in_*=1 -> led_*=0, settled=1 immediately (async). After release with in_*=0, led_* stays 0 for 200 cycles and settled stays 1.
- Fade up, red: set in_r=1 at reset release -> settled drops next cycle. Red duty reaches 15 after 15 step_ticks (60 clocks); red duty_active=15 by the next period end after that. led_r is then constantly 1 and settled=1. Duty-ratio check, high clocks per 16-clock period: duty_active=3 gives exactly 3; duty_active=8 gives exactly 8.
- Reversal mid-ramp: in_g=1 until green duty=6, then in_g=0 -> next step_tick gives duty 5. Duty reaches 0 after 6 total down-steps, then led_g stays 0 and settled=1.
- Period-boundary update: force a step_tick on the cycle pwm_cnt==15 -> duty_active updates once per 16 clocks only. led_r shows no runt pulse; every high pulse length equals the duty_active latched at the period start.
- ACTIVE_LOW=1, STEP_DIV=1: in_b=1 -> led_b idles 1 out of reset. It reaches constant 0 once duty_active=15. Red and green stay constant 1.
- Reset mid-ramp: rst pulse while all duties=9 -> outputs off within the same cycle. After release, duties ramp again from 0 (first step observed STEP_DIV clocks later).
